hazard_controller: RTL and testbench

Central sequencing block for the five-stage pipelined RV32I core. It generates the stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers, and the operand-forwarding selects for the execute stage. It also runs a request/ready handshake with a variable-latency data memory, freezing the pipeline while an access is outstanding. The block sits beside the pipeline registers and drives their enable and clear inputs.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/dmem_wait_fsm.sv | 89 ++++++++
 rtl/hazard_controller.sv | 109 ++++++++++
 tb/tb_hazard_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        ERROR = 2'b10
    } mem_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

endpackage

// File: rtl/dmem_wait_fsm.sv
// Data-memory request/ready tracker: freezes the pipeline while an access is
// outstanding and latches a sticky fault if ready never comes.
module dmem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_access,
    input  logic dmem_ready,
    output logic mem_stall,
    output logic dmem_req,
    output logic mem_timeout
);

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = TIMEOUT_WIDTH'(1);

    mem_state_t               state_r;
    mem_state_t               state_next_s;
    logic [TIMEOUT_WIDTH-1:0] cnt_r;
    logic [TIMEOUT_WIDTH-1:0] cnt_next_s;
    logic                     mem_timeout_r;
    logic                     mem_stall_s;
    logic                     dmem_req_s;

    // Next-state, wait counter and raw stall/request decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        mem_stall_s  = 1'b0;
        dmem_req_s   = 1'b0;
        case (state_r)
            IDLE: begin
                dmem_req_s = mem_access;
                if (mem_access && !dmem_ready) begin
                    mem_stall_s  = 1'b1;
                    state_next_s = WAIT;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                dmem_req_s = 1'b1;
                if (dmem_ready) begin
                    state_next_s = IDLE;
                end else begin
                    mem_stall_s = 1'b1;
                    cnt_next_s  = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_next_s = ERROR;
                    end else begin
                        state_next_s = WAIT;
                    end
                end
            end
            ERROR: begin
                mem_stall_s  = 1'b1;
                state_next_s = ERROR;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State, counter and sticky fault flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            mem_timeout_r <= (state_next_s == ERROR);
        end
    end

    // Reset gating makes an aborted access drop its request immediately.
    assign mem_stall   = rst_n & mem_stall_s;
    assign dmem_req    = rst_n & dmem_req_s;
    assign mem_timeout = mem_timeout_r;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forwarding sequencer for the five-stage RV32I pipeline, with a
// data-memory wait tracker that overrides every other hazard while active.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int MEM_TIMEOUT            = 255,
    parameter int TIMEOUT_WIDTH          = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
    input  logic [1:0]                        ResultSrcE,
    input  logic                              PCSrcE,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW,
    input  logic                              RegWriteM,
    input  logic                              RegWriteW,
    input  logic                              MemAccessM,
    input  logic                              dmem_ready,
    output logic                              dmem_req,
    output logic                              StallF,
    output logic                              StallD,
    output logic                              StallE,
    output logic                              StallM,
    output logic                              FlushD,
    output logic                              FlushE,
    output logic                              FlushW,
    output logic [1:0]                        ForwardAE,
    output logic [1:0]                        ForwardBE,
    output logic                              mem_timeout
);

    localparam logic [REGISTER_ADDRESS_WIDTH-1:0] REG_ZERO = '0;

    logic mem_stall_s;
    logic lw_stall_s;

    function automatic logic [1:0] fwd_sel(
        input logic [REGISTER_ADDRESS_WIDTH-1:0] rs,
        input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_m,
        input logic                              wr_m,
        input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_w,
        input logic                              wr_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

    dmem_wait_fsm #(
        .MEM_TIMEOUT   (MEM_TIMEOUT),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_dmem_wait_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_access  (MemAccessM),
        .dmem_ready  (dmem_ready),
        .mem_stall   (mem_stall_s),
        .dmem_req    (dmem_req),
        .mem_timeout (mem_timeout)
    );

    assign lw_stall_s = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != REG_ZERO) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // Stall/flush priority: memory freeze suppresses load-use and branch
    // flushes so a frozen branch in E is re-resolved once memory releases.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_REG;
        ForwardBE = FWD_REG;
        if (!rst_n) begin
            StallF = 1'b0;
        end else begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            if (mem_stall_s) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall_s;
                StallD = lw_stall_s;
                FlushD = PCSrcE;
                FlushE = lw_stall_s | PCSrcE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed plus randomized bench for hazard_controller against a cycle-counting
// reference model of the memory handshake and the hazard rules.
module tb_hazard_controller;

    localparam int AW = 5;
    localparam int TO = 4;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, RegWriteM, RegWriteW, MemAccessM, dmem_ready;
    logic          dmem_req, StallF, StallD, StallE, StallM;
    logic          FlushD, FlushE, FlushW, mem_timeout;
    logic [1:0]    ForwardAE, ForwardBE;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: outstanding access flag, WAIT cycles elapsed, fault.
    bit m_busy;
    int m_waited;
    bit m_fault;

    always #5 clk = ~clk;

    hazard_controller #(
        .REGISTER_ADDRESS_WIDTH (AW),
        .MEM_TIMEOUT            (TO),
        .TIMEOUT_WIDTH          (TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemAccessM(MemAccessM), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_timeout(mem_timeout)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_outputs(input string ctx);
        logic       exp_mstall, exp_req, lw, exp_to;
        logic [3:0] exp_st;
        logic [2:0] exp_fl;
        logic [3:0] exp_fw;
        if (!rst_n) begin
            exp_st = 4'b0000; exp_fl = 3'b000; exp_fw = 4'b0000;
            exp_req = 1'b0; exp_to = 1'b0;
        end else begin
            exp_mstall = m_fault || (m_busy ? !dmem_ready : (MemAccessM && !dmem_ready));
            exp_req    = !m_fault && (m_busy || MemAccessM);
            exp_to     = m_fault;
            lw = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
            if (exp_mstall) begin
                exp_st = 4'b1111;
                exp_fl = 3'b001;
            end else begin
                exp_st = {lw, lw, 2'b00};
                exp_fl = {PCSrcE, lw | PCSrcE, 1'b0};
            end
            exp_fw = {fwd_ref(Rs1E), fwd_ref(Rs2E)};
        end
        check({ctx, ".stall_FDEM"}, {4'b0, StallF, StallD, StallE, StallM}, {4'b0, exp_st});
        check({ctx, ".flush_DEW"}, {5'b0, FlushD, FlushE, FlushW}, {5'b0, exp_fl});
        check({ctx, ".fwd_AB"}, {4'b0, ForwardAE, ForwardBE}, {4'b0, exp_fw});
        check({ctx, ".dmem_req"}, {7'b0, dmem_req}, {7'b0, exp_req});
        check({ctx, ".mem_timeout"}, {7'b0, mem_timeout}, {7'b0, exp_to});
    endtask

    task automatic update_model();
        if (!rst_n) begin
            m_busy = 1'b0; m_waited = 0; m_fault = 1'b0;
        end else if (m_fault) begin
            m_fault = 1'b1;
        end else if (m_busy) begin
            if (dmem_ready) begin
                m_busy = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    m_fault = 1'b1;
                    m_busy  = 1'b0;
                end
            end
        end else if (MemAccessM && !dmem_ready) begin
            m_busy = 1'b1; m_waited = 0;
        end
    endtask

    // Inputs are applied on the falling edge; check, then advance one cycle.
    task automatic step(input string ctx);
        #1;
        check_outputs(ctx);
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemAccessM = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        m_busy = 1'b0; m_waited = 0; m_fault = 1'b0;
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        step("reset");
        rst_n = 1'b1;

        // Load-use hazard, then RdE=x0 suppresses it.
        ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
        step("lw_use");
        RdE = 5'd0;
        step("lw_x0");
        RdE = 5'd5; PCSrcE = 1'b1;
        step("branch_lw");
        clear_inputs();

        // Forwarding priority.
        RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1;
        step("fwd_m");
        RegWriteM = 1'b0;
        step("fwd_w");
        Rs1E = 5'd0;
        step("fwd_x0");
        clear_inputs();

        // Three-cycle access, idle, zero-wait, back-to-back after release.
        MemAccessM = 1'b1;
        step("acc3_c1");
        step("acc3_c2");
        dmem_ready = 1'b1;
        step("acc3_c3");
        MemAccessM = 1'b0; dmem_ready = 1'b0;
        step("acc3_idle");
        MemAccessM = 1'b1; dmem_ready = 1'b1;
        step("zero_wait");
        dmem_ready = 1'b0;
        step("b2b_c1");
        dmem_ready = 1'b1;
        step("b2b_rel");

        // Branch resolved during a memory freeze is re-evaluated after release.
        dmem_ready = 1'b0; PCSrcE = 1'b1;
        step("br_mem_c1");
        step("br_mem_c2");
        dmem_ready = 1'b1;
        step("br_mem_rel");
        clear_inputs();

        // Ready in the last allowed WAIT cycle wins over the timeout.
        MemAccessM = 1'b1;
        for (int i = 0; i < TO; i++) step("ready_wins_wait");
        dmem_ready = 1'b1;
        step("ready_wins_rel");
        clear_inputs();
        step("ready_wins_idle");

        // Timeout into ERROR, then reset clears it.
        MemAccessM = 1'b1;
        for (int i = 0; i < TO + 1; i++) step("timeout_wait");
        MemAccessM = 1'b0;
        step("error_1");
        dmem_ready = 1'b1;
        step("error_2");
        rst_n = 1'b0;
        step("error_rst");
        rst_n = 1'b1;
        clear_inputs();
        step("after_rst");

        // Asynchronous reset mid-WAIT drops the request at once.
        MemAccessM = 1'b1;
        step("async_c1");
        @(posedge clk);
        update_model();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.dmem_req", {7'b0, dmem_req}, 8'h00);
        check("async_rst.stallF", {7'b0, StallF}, 8'h00);
        update_model();
        @(negedge clk);
        step("async_hold");
        rst_n = 1'b1;
        clear_inputs();

        // Randomized traffic with periodic resets.
        for (int i = 0; i < 600; i++) begin
            rst_n      = (i % 53 == 52) ? 1'b0 : 1'b1;
            Rs1D       = AW'($urandom_range(0, 3));
            Rs2D       = AW'($urandom_range(0, 3));
            Rs1E       = AW'($urandom_range(0, 3));
            Rs2E       = AW'($urandom_range(0, 3));
            RdE        = AW'($urandom_range(0, 3));
            RdM        = AW'($urandom_range(0, 3));
            RdW        = AW'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            MemAccessM = ($urandom_range(0, 2) == 0);
            dmem_ready = 1'($urandom_range(0, 1));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
